// File: rtl/regfile_access_master.sv
// regfile_access_master: initiator-side sequencer for the 8-bit x 16-entry
// register file. Takes single or burst read/write commands, streams write
// beats into the file, and returns read beats on a valid/ready response channel.
module regfile_access_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // write data channel
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  // read response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  // status
  output logic              done,
  output logic              busy,
  // register-file side
  output logic              rf_wrEN,
  output logic              rf_rdEN,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_wrData,
  input  logic [DATA_W-1:0] rf_rdData
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nxt;

  logic cmd_acc_c;
  logic wr_acc_c;
  logic rsp_acc_c;

  // Handshakes use only registered ready/valid, so no valid<->ready loop exists.
  assign cmd_acc_c = cmd_valid & cmd_ready;
  assign wr_acc_c  = wdata_valid & wdata_ready;
  assign rsp_acc_c = rsp_valid & rsp_ready;

  // State, address and beat-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Next-state, next-address and next-count; counter==0 marks the last beat.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (cmd_acc_c) begin
          addr_nxt  = cmd_addr;
          cnt_nxt   = cmd_len;
          state_nxt = cmd_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        if (wr_acc_c) begin
          addr_nxt = addr_q + ADDR_W'(1);
          cnt_nxt  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_nxt = DONE;
          end
        end
      end
      RD_ISSUE: begin
        state_nxt = RD_CAPT;
      end
      RD_CAPT: begin
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (rsp_acc_c) begin
          addr_nxt  = addr_q + ADDR_W'(1);
          cnt_nxt   = cnt_q - LEN_W'(1);
          state_nxt = (cnt_q == '0) ? DONE : RD_ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status and handshake outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      done        <= 1'b0;
    end else begin
      cmd_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      wdata_ready <= (state_nxt == WR);
      rsp_valid   <= (state_nxt == RD_WAIT);
      done        <= (state_nxt == DONE);
    end
  end

  // Register-file strobes; address/data only move together with a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wrEN    <= 1'b0;
      rf_rdEN    <= 1'b0;
      rf_address <= '0;
      rf_wrData  <= '0;
    end else begin
      rf_wrEN <= wr_acc_c;
      rf_rdEN <= (state_nxt == RD_ISSUE);
      if (state_nxt == RD_ISSUE) begin
        rf_address <= addr_nxt;
      end else if (wr_acc_c) begin
        rf_address <= addr_q;
        rf_wrData  <= wdata;
      end
    end
  end

  // Read data is captured only in the cycle after the read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
    end else if (state == RD_CAPT) begin
      rsp_data <= rf_rdData;
    end
  end

endmodule
